// File: rtl/store_write_buffer_pkg.sv
// rtl/store_write_buffer_pkg.sv - shared types and funct3 encodings for the store write buffer
package store_write_buffer_pkg;

   typedef logic [31:0] word_t;
   typedef logic [2:0]  funct3_t;
   typedef logic [3:0]  be_t;

   localparam funct3_t F3_SB  = 3'b000;
   localparam funct3_t F3_SH  = 3'b001;
   localparam funct3_t F3_SW  = 3'b010;
   localparam funct3_t F3_LB  = 3'b000;
   localparam funct3_t F3_LH  = 3'b001;
   localparam funct3_t F3_LW  = 3'b010;
   localparam funct3_t F3_LBU = 3'b100;
   localparam funct3_t F3_LHU = 3'b101;

   typedef struct packed {
      logic [29:0] addr;
      word_t       data;
      be_t         be;
   } store_entry_t;

   // Byte-lane mask for an access of size code sz at byte offset ofs; lanes past the word are dropped.
   function automatic be_t size_mask(input logic [1:0] sz, input logic [1:0] ofs);
      logic [7:0] m;
      case (sz)
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         2'b10:   m = 8'h0f;
         default: m = 8'h00;
      endcase
      m = m << ofs;
      return m[3:0];
   endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// rtl/store_write_buffer_if.sv - pipeline store/load-check and memory write signals of the buffer
interface store_write_buffer_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
);
   import store_write_buffer_pkg::*;

   logic             st_valid;
   logic             st_ready;
   word_t            st_addr;
   word_t            st_data;
   funct3_t          st_type;
   logic             st_error;
   logic             ld_check;
   word_t            ld_addr;
   funct3_t          ld_type;
   logic             ld_conflict;
   logic             mem_wr_valid;
   logic             mem_wr_ready;
   word_t            mem_wr_addr;
   word_t            mem_wr_data;
   be_t              mem_wr_be;
   logic             empty;
   logic [CNT_W-1:0] count;

   modport master (
      output st_valid, st_addr, st_data, st_type, ld_check, ld_addr, ld_type, mem_wr_ready,
      input  st_ready, st_error, ld_conflict, mem_wr_valid, mem_wr_addr, mem_wr_data,
             mem_wr_be, empty, count
   );

   modport slave (
      input  st_valid, st_addr, st_data, st_type, ld_check, ld_addr, ld_type, mem_wr_ready,
      output st_ready, st_error, ld_conflict, mem_wr_valid, mem_wr_addr, mem_wr_data,
             mem_wr_be, empty, count
   );

endinterface

// File: rtl/store_align.sv
// rtl/store_align.sv - store lane alignment/legality and load byte mask for the conflict check
module store_align
   import store_write_buffer_pkg::*;
(
   input  funct3_t    st_type,
   input  logic [1:0] st_ofs,
   input  word_t      st_data,
   input  funct3_t    ld_type,
   input  logic [1:0] ld_ofs,
   output be_t        st_be,
   output word_t      st_lane_data,
   output logic       st_bad,
   output be_t        ld_mask
);

   logic ld_legal;

   always_comb begin
      st_be        = size_mask(st_type[1:0], st_ofs);
      st_lane_data = st_data;
      st_bad       = 1'b0;
      case (st_type)
         F3_SB: st_lane_data = {4{st_data[7:0]}};
         F3_SH: begin
            st_lane_data = {2{st_data[15:0]}};
            st_bad       = st_ofs[0];
         end
         F3_SW:   st_bad = (st_ofs != 2'b00);
         default: st_bad = 1'b1;
      endcase
   end

   // Unsigned word loads and the 011 code do not exist, so they never conflict.
   assign ld_legal = (ld_type[1:0] != 2'b11) && !(ld_type[2] && ld_type[1]);
   assign ld_mask  = ld_legal ? size_mask(ld_type[1:0], ld_ofs) : 4'b0000;

endmodule

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - in-order store FIFO draining to data memory with load hazard detection
module store_write_buffer
   import store_write_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
)(
   input  logic                 clock,
   input  logic                 reset,
   store_write_buffer_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);

   store_entry_t     entries [DEPTH];
   logic [DEPTH-1:0] entry_vld;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_nxt;
   logic             empty_q;
   logic             st_error_q;
   be_t              st_be;
   be_t              ld_mask;
   word_t            st_lane_data;
   logic             st_bad;
   logic             full;
   logic             push;
   logic             pop;
   logic             hit;

   store_align u_align (
      .st_type      (bus.st_type),
      .st_ofs       (bus.st_addr[1:0]),
      .st_data      (bus.st_data),
      .ld_type      (bus.ld_type),
      .ld_ofs       (bus.ld_addr[1:0]),
      .st_be        (st_be),
      .st_lane_data (st_lane_data),
      .st_bad       (st_bad),
      .ld_mask      (ld_mask)
   );

   assign full      = (count_q == CNT_W'(DEPTH));
   assign push      = bus.st_valid & ~full & ~st_bad;
   assign pop       = ~empty_q & bus.mem_wr_ready;
   assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head       <= '0;
         tail       <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         entry_vld  <= '0;
         st_error_q <= 1'b0;
      end else begin
         st_error_q <= bus.st_valid & st_bad;
         count_q    <= count_nxt;
         empty_q    <= (count_nxt == '0);
         if (push) begin
            tail            <= tail + PTR_W'(1);
            entry_vld[tail] <= 1'b1;
         end
         if (pop) begin
            head            <= head + PTR_W'(1);
            entry_vld[head] <= 1'b0;
         end
      end
   end

   // Payload needs no reset: the valid bits and the empty gating hide stale contents.
   always_ff @(posedge clock) begin
      if (push) begin
         entries[tail] <= '{addr: bus.st_addr[31:2], data: st_lane_data, be: st_be};
      end
   end

   // The entry being popped this cycle still counts, and so does the store arriving now.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_vld[i] && (entries[i].addr == bus.ld_addr[31:2]) && |(entries[i].be & ld_mask)) begin
            hit = 1'b1;
         end
      end
      if (bus.st_valid && !st_bad && (bus.st_addr[31:2] == bus.ld_addr[31:2]) && |(st_be & ld_mask)) begin
         hit = 1'b1;
      end
   end

   assign bus.ld_conflict  = bus.ld_check & hit;
   assign bus.st_ready     = ~full;
   assign bus.st_error     = st_error_q;
   assign bus.mem_wr_valid = ~empty_q;
   assign bus.mem_wr_addr  = empty_q ? '0 : {entries[head].addr, 2'b00};
   assign bus.mem_wr_data  = empty_q ? '0 : entries[head].data;
   assign bus.mem_wr_be    = empty_q ? '0 : entries[head].be;
   assign bus.empty        = empty_q;
   assign bus.count        = count_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - scoreboard bench for store_write_buffer against a byte-level model
module tb_store_write_buffer;
   import store_write_buffer_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] baddr;
      int          size;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   store_write_buffer_if #(.DEPTH(DEPTH)) bus ();
   store_write_buffer #(.DEPTH(DEPTH)) dut (.clock(clk), .reset(rst_n), .bus(bus));

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   bit   model_on = 0;
   bit   exp_err  = 0;
   bit   exp_conf;
   bit   legal;
   int   n;
   exp_t e_mon;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int st_size(input logic [2:0] t);
      case (t)
         3'b000:  return 1;
         3'b001:  return 2;
         3'b010:  return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit st_legal(input logic [2:0] t, input logic [31:0] a);
      int s;
      s = st_size(t);
      return (s != 0) && ((a % s) == 0);
   endfunction

   function automatic int ld_size(input logic [2:0] t);
      case (t)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   // A load only touches bytes inside its own word; compare actual byte addresses.
   function automatic bit overlap(input logic [31:0] sa, input int ss, input logic [31:0] la, input int ls);
      logic [31:0] lb;
      for (int i = 0; i < ls; i++) begin
         lb = la + 32'(i);
         if (lb[31:2] == la[31:2]) begin
            for (int j = 0; j < ss; j++) begin
               if (sa + 32'(j) == lb) return 1;
            end
         end
      end
      return 0;
   endfunction

   function automatic exp_t make_exp(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
      exp_t e;
      e.baddr = a;
      e.size  = st_size(t);
      e.addr  = a & ~32'h3;
      e.be    = 4'b0000;
      for (int j = 0; j < e.size; j++) e.be[int'(a % 4) + j] = 1'b1;
      if (e.size == 1)      e.data = {24'h0, d[7:0]} * 32'h01010101;
      else if (e.size == 2) e.data = {16'h0, d[15:0]} * 32'h00010001;
      else                  e.data = d;
      return e;
   endfunction

   // Model: checks state against the pending list, then records what the coming edge accepts.
   always @(negedge clk) begin
      if (model_on && rst_n) begin
         n = exp_q.size();
         chk("count", 32'(bus.count), 32'(n));
         chk("empty", 32'(bus.empty), 32'(n == 0));
         chk("mem_wr_valid", 32'(bus.mem_wr_valid), 32'(n != 0));
         chk("st_ready", 32'(bus.st_ready), 32'(n < DEPTH));
         chk("st_error", 32'(bus.st_error), 32'(exp_err));
         legal    = bus.st_valid && st_legal(bus.st_type, bus.st_addr);
         exp_conf = 0;
         if (bus.ld_check) begin
            foreach (exp_q[i]) begin
               if (overlap(exp_q[i].baddr, exp_q[i].size, bus.ld_addr, ld_size(bus.ld_type))) exp_conf = 1;
            end
            if (legal && overlap(bus.st_addr, st_size(bus.st_type), bus.ld_addr, ld_size(bus.ld_type))) exp_conf = 1;
         end
         chk("ld_conflict", 32'(bus.ld_conflict), 32'(exp_conf));
         exp_err = bus.st_valid && !legal;
         if (legal && n < DEPTH) exp_q.push_back(make_exp(bus.st_addr, bus.st_data, bus.st_type));
      end
   end

   // Monitor: every write handshake must match the oldest expected store.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (model_on && rst_n && bus.mem_wr_valid && bus.mem_wr_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %h, expected no write", bus.mem_wr_addr);
            end else begin
               e_mon = exp_q.pop_front();
               chk("wr_addr", bus.mem_wr_addr, e_mon.addr);
               chk("wr_data", bus.mem_wr_data, e_mon.data);
               chk("wr_be", 32'(bus.mem_wr_be), 32'(e_mon.be));
            end
         end
      end
   end

   task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                      input bit lc, input logic [31:0] la, input logic [2:0] lt, input bit rdy);
      bus.st_valid     = v;
      bus.st_addr      = a;
      bus.st_data      = d;
      bus.st_type      = t;
      bus.ld_check     = lc;
      bus.ld_addr      = la;
      bus.ld_type      = lt;
      bus.mem_wr_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit rdy, input int cycles);
      for (int i = 0; i < cycles; i++) cyc(0, 0, 0, 0, 0, 0, 0, rdy);
   endtask

   task automatic ld_probe(input string name, input logic [31:0] la, input logic [2:0] lt, input bit exp);
      bus.ld_check = 1'b1;
      bus.ld_addr  = la;
      bus.ld_type  = lt;
      #1;
      chk(name, 32'(bus.ld_conflict), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   logic [2:0] rt;
   bit         acc;
   bit         took;

   initial begin
      bus.st_valid = 0; bus.st_addr = 0; bus.st_data = 0; bus.st_type = 0;
      bus.ld_check = 0; bus.ld_addr = 0; bus.ld_type = 0; bus.mem_wr_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.mem_wr_valid), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_error", 32'(bus.st_error), 32'd0);
      chk("rst_addr", bus.mem_wr_addr, 32'd0);
      chk("rst_be", 32'(bus.mem_wr_be), 32'd0);
      rst_n    = 1'b1;
      model_on = 1;

      // sw straight through
      cyc(1, 32'h100, 32'hDEADBEEF, F3_SW, 0, 0, 0, 1);
      chk("t1_valid", 32'(bus.mem_wr_valid), 32'd1);
      chk("t1_addr", bus.mem_wr_addr, 32'h100);
      chk("t1_data", bus.mem_wr_data, 32'hDEADBEEF);
      chk("t1_be", 32'(bus.mem_wr_be), 32'hF);
      idle(1, 1);
      chk("t1_empty", 32'(bus.empty), 32'd1);

      // sb and sh lane placement
      cyc(1, 32'h203, 32'h000000AB, F3_SB, 0, 0, 0, 0);
      cyc(1, 32'h206, 32'h00001234, F3_SH, 0, 0, 0, 0);
      chk("t2_addr", bus.mem_wr_addr, 32'h200);
      chk("t2_data", bus.mem_wr_data, 32'hABABABAB);
      chk("t2_be", 32'(bus.mem_wr_be), 32'h8);
      idle(1, 3);

      // fill, back-pressure, then drain with a held fifth store
      for (int i = 0; i < 4; i++) cyc(1, 32'h500 + 32'(i * 4), $urandom, F3_SW, 0, 0, 0, 0);
      chk("t3_count", 32'(bus.count), 32'd4);
      chk("t3_ready", 32'(bus.st_ready), 32'd0);
      cyc(1, 32'h520, 32'h55667788, F3_SW, 0, 0, 0, 0);
      took = 0;
      for (int k = 0; k < 10 && !took; k++) begin
         acc = bus.st_ready;
         cyc(1, 32'h520, 32'h55667788, F3_SW, 0, 0, 0, 1);
         took = acc;
      end
      chk("t3_fifth_accepted", 32'(took), 32'd1);
      idle(1, 6);

      // rejected stores
      cyc(1, 32'h101, 32'h1111, F3_SH, 0, 0, 0, 1);
      chk("t4_err_sh", 32'(bus.st_error), 32'd1);
      cyc(1, 32'h102, 32'h2222, F3_SW, 0, 0, 0, 1);
      chk("t4_err_sw", 32'(bus.st_error), 32'd1);
      idle(1, 1);
      chk("t4_err_clear", 32'(bus.st_error), 32'd0);
      chk("t4_count", 32'(bus.count), 32'd0);

      // load conflict against a pending sb
      cyc(1, 32'h303, 32'h000000CD, F3_SB, 0, 0, 0, 0);
      bus.st_valid = 0;
      ld_probe("t5_lb_302", 32'h302, F3_LB, 0);
      ld_probe("t5_lw_300", 32'h300, F3_LW, 1);
      ld_probe("t5_lbu_303", 32'h303, F3_LBU, 1);
      idle(1, 2);
      ld_probe("t5_after_drain", 32'h300, F3_LW, 0);

      // reset in the middle of a drain
      for (int i = 0; i < 3; i++) cyc(1, 32'h600 + 32'(i * 4), $urandom, F3_SW, 0, 0, 0, 0);
      bus.st_valid     = 0;
      bus.ld_check     = 0;
      bus.mem_wr_ready = 1;
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", 32'(bus.mem_wr_valid), 32'd0);
      chk("t6_empty", 32'(bus.empty), 32'd1);
      chk("t6_count", 32'(bus.count), 32'd0);
      exp_q.delete();
      exp_err = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1, 3);
      chk("t6_no_write", 32'(bus.mem_wr_valid), 32'd0);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: rt = F3_SB;
            3, 4, 5: rt = F3_SH;
            6, 7:    rt = F3_SW;
            8:       rt = 3'b011;
            default: rt = 3'($urandom_range(4, 7));
         endcase
         cyc($urandom_range(0, 9) < 6, 32'h400 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
             $urandom, rt, 1'($urandom_range(0, 1)),
             32'h400 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0) ? F3_LW : 3'($urandom_range(0, 1) * 4 + $urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      end
      idle(1, DEPTH + 2);
      chk("final_empty", 32'(bus.empty), 32'd1);
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
